// File: rtl/reg_dump_uart.sv
// rtl/reg_dump_uart.sv - walks a register-file index range and streams each 32-bit word MSB-byte-first over UART TX
// Optional even-parity bit per frame when REG_DUMP_PARITY_EN is defined (8E1 instead of 8N1).
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int REG_FIRST    = 0,
    parameter int REG_LAST     = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [31:0] rd,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [4:0]    idx;
    logic [31:0]   word;
    logic [7:0]    cur_byte;
    logic          baud_end;
    logic          tx_nxt;
    logic          last_byte;
    logic          last_reg;

    assign baud_end  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign last_byte = (byte_cnt == 2'd3);
    assign last_reg  = (idx == 5'(REG_LAST));
    assign ra        = idx;

    always_comb begin
        cur_byte = word[31:24];
        case (byte_cnt)
            2'd0: cur_byte = word[31:24];
            2'd1: cur_byte = word[23:16];
            2'd2: cur_byte = word[15:8];
            2'd3: cur_byte = word[7:0];
            default: cur_byte = word[31:24];
        endcase
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_START;
            S_START: begin
                tx_nxt = 1'b0;
                if (baud_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                tx_nxt = cur_byte[bit_cnt];
                if (baud_end && bit_cnt == 3'd7) begin
`ifdef REG_DUMP_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                tx_nxt = ^cur_byte;
                if (baud_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (baud_end) begin
                    if (!last_byte)     state_nxt = S_START;
                    else if (!last_reg) state_nxt = S_LOAD;
                    else                state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters advance only inside a frame so every bit is exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            idx      <= 5'(REG_FIRST);
            word     <= '0;
        end else begin
            if (state == S_START || state == S_DATA || state == S_PARITY || state == S_STOP) begin
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
            end
            if (state == S_DATA && baud_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == S_IDLE && start) begin
                byte_cnt <= '0;
                idx      <= 5'(REG_FIRST);
            end else if (state == S_STOP && baud_end) begin
                if (!last_byte) begin
                    byte_cnt <= byte_cnt + 2'd1;
                end else begin
                    byte_cnt <= '0;
                    if (!last_reg) idx <= idx + 5'd1;
                end
            end
            if (state == S_LOAD) begin
                word <= rd;
            end
        end
    end

    // Outputs are registered one cycle behind the state so tx is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx   <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            tx   <= tx_nxt;
            busy <= (state != S_IDLE) && (state != S_DONE);
            done <= (state == S_DONE);
        end
    end
endmodule
